// File: rtl/cache_ctrl_pkg.sv
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared state encoding and block geometry for cache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_ctrl_pkg;

  localparam int BLOCK_WORDS = 4;
  localparam int BEAT_W      = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REFILL     = 2'd1,
    WRITE_MEM  = 2'd2,
    WRITE_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cache_perf_counter.sv
// ============================================================================
// Module      : cache_perf_counter
// Description : Saturating event counter used for cache hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
// Module      : cache_controller
// Description : Write-through, no-write-allocate controller for a direct-mapped
//               cache; block refill on read miss, CPU stall while memory busy.
//               Optional hit/miss counters under CACHE_CTRL_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int BLOCK_WORDS = cache_ctrl_pkg::BLOCK_WORDS,
  parameter int BEAT_W      = cache_ctrl_pkg::BEAT_W
`ifdef CACHE_CTRL_PERF_CNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              hit,
  input  logic              mem_ready,
  output logic              read_from_cache,
  output logic              write_in_cache,
  output logic              move_to_cache,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [BEAT_W-1:0] refill_beat,
  output logic              stall
`ifdef CACHE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
`endif
);

  state_t            r_state;
  state_t            w_next_state;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_beat_next;
  logic              w_last_beat;

  assign w_last_beat = (r_beat == BEAT_W'(BLOCK_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_beat_next;
    end
  end

  // A simultaneous read and write is resolved as a write.
  always_comb begin
    w_next_state = r_state;
    w_beat_next  = r_beat;
    case (r_state)
      IDLE: begin
        if (mem_write) begin
          w_next_state = WRITE_MEM;
        end else if (mem_read && !hit) begin
          w_next_state = REFILL;
          w_beat_next  = '0;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          if (w_last_beat) begin
            w_next_state = IDLE;
            w_beat_next  = '0;
          end else begin
            w_beat_next  = r_beat + 1'b1;
          end
        end
      end
      WRITE_MEM: begin
        if (mem_ready) begin
          w_next_state = WRITE_DONE;
        end
      end
      WRITE_DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        w_beat_next  = '0;
      end
    endcase
  end

  // Outputs are forced low while rst is high, independent of the stored state.
  always_comb begin
    read_from_cache = 1'b0;
    write_in_cache  = 1'b0;
    move_to_cache   = 1'b0;
    mem_rd_req      = 1'b0;
    mem_wr_req      = 1'b0;
    refill_beat     = '0;
    stall           = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (mem_write) begin
            stall          = 1'b1;
            write_in_cache = hit;
          end else if (mem_read) begin
            if (hit) begin
              read_from_cache = 1'b1;
            end else begin
              stall      = 1'b1;
              mem_rd_req = 1'b1;
            end
          end
        end
        REFILL: begin
          stall         = 1'b1;
          mem_rd_req    = 1'b1;
          refill_beat   = r_beat;
          move_to_cache = mem_ready;
        end
        WRITE_MEM: begin
          stall      = 1'b1;
          mem_wr_req = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic w_hit_evt;
  logic w_miss_evt;

  assign w_hit_evt  = (r_state == IDLE) && !mem_write && mem_read && hit;
  assign w_miss_evt = (r_state == IDLE) && !mem_write && mem_read && !hit;

  cache_perf_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hit_evt),
    .o_count (hit_count)
  );

  cache_perf_counter #(
    .CNT_W (CNT_W)
  ) u_miss_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_miss_evt),
    .o_count (miss_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
// Module      : tb_cache_controller
// Description : Directed self-checking bench for cache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read;
  logic       mem_write;
  logic       hit;
  logic       mem_ready;
  logic       read_from_cache;
  logic       write_in_cache;
  logic       move_to_cache;
  logic       mem_rd_req;
  logic       mem_wr_req;
  logic [1:0] refill_beat;
  logic       stall;
`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  // {read, write, move, rd_req, wr_req, beat[1:0], stall}
  logic [7:0] obs;
  assign obs = {read_from_cache, write_in_cache, move_to_cache, mem_rd_req,
                mem_wr_req, refill_beat, stall};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .hit             (hit),
    .mem_ready       (mem_ready),
    .read_from_cache (read_from_cache),
    .write_in_cache  (write_in_cache),
    .move_to_cache   (move_to_cache),
    .mem_rd_req      (mem_rd_req),
    .mem_wr_req      (mem_wr_req),
    .refill_beat     (refill_beat),
    .stall           (stall)
`ifdef CACHE_CTRL_PERF_CNT_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %b want %b", i, obs, 8'h00);
      end
      next_cycle();
    end
    rst = 1'b0; mem_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_release_idle[%0d]: got %b want %b", i, obs, 8'h00);
      end
      next_cycle();
    end
  endtask

  task automatic test_read_hit();
    mem_read = 1'b1; hit = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== 8'h80) begin
        n_fail++;
        $display("FAIL read_hit[%0d]: got %b want %b", i, obs, 8'h80);
      end
      next_cycle();
    end
    mem_read = 1'b0; hit = 1'b0;
  endtask

  task automatic test_read_miss();
    logic       hit_v   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ready_v [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_v   [8] = '{8'h11, 8'h31, 8'h13, 8'h33, 8'h35, 8'h17, 8'h37, 8'h80};
    for (int i = 0; i < 8; i++) begin
      mem_read = 1'b1; hit = hit_v[i]; mem_ready = ready_v[i];
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL read_miss[%0d]: got %b want %b", i, obs, exp_v[i]);
      end
      next_cycle();
    end
    mem_read = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL read_miss_idle: got %b want %b", obs, 8'h00);
    end
    next_cycle();
  endtask

  // Rows: store hit, store miss, read+write together (treated as write).
  task automatic test_store();
    logic [3:0] stim  [14] = '{4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1010, 4'b0000,
                               4'b1000, 4'b1001, 4'b1000, 4'b0000,
                               4'b1110, 4'b1111, 4'b1110, 4'b0000};
    logic [7:0] exp_v [14] = '{8'h41, 8'h09, 8'h09, 8'h09, 8'h00, 8'h00,
                               8'h01, 8'h09, 8'h00, 8'h00,
                               8'h41, 8'h09, 8'h00, 8'h00};
    for (int i = 0; i < 14; i++) begin
      {mem_write, mem_read, hit, mem_ready} = stim[i];
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL store[%0d]: got %b want %b", i, obs, exp_v[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [3:0] stim  [6] = '{4'b0100, 4'b0101, 4'b0101, 4'b1101, 4'b0100, 4'b0100};
    logic [7:0] exp_v [6] = '{8'h11, 8'h31, 8'h33, 8'h00, 8'h11, 8'h11};
    for (int i = 0; i < 6; i++) begin
      {rst, mem_read, hit, mem_ready} = stim[i];
      mem_write = 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reset_mid_refill[%0d]: got %b want %b", i, obs, exp_v[i]);
      end
      next_cycle();
    end
    rst = 1'b1; mem_read = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_refill_idle: got %b want %b", obs, 8'h00);
    end
    next_cycle();
  endtask

`ifdef CACHE_CTRL_PERF_CNT_EN
  task automatic test_perf_counters();
    logic [2:0] stim [13] = '{3'b100, 3'b101, 3'b101, 3'b101, 3'b101, 3'b110,
                              3'b100, 3'b101, 3'b101, 3'b101, 3'b101, 3'b110,
                              3'b110};
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      {mem_read, hit, mem_ready} = stim[i];
      next_cycle();
    end
    mem_read = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    n_tests++;
    if (hit_count !== 16'd3) begin
      n_fail++;
      $display("FAIL perf_hit_count: got %0d want %0d", hit_count, 3);
    end
    n_tests++;
    if (miss_count !== 16'd2) begin
      n_fail++;
      $display("FAIL perf_miss_count: got %0d want %0d", miss_count, 2);
    end
    mem_read = 1'b1; hit = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    n_tests++;
    if (hit_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_hit_full: got %h want %h", hit_count, 16'hFFFF);
    end
    repeat (2) next_cycle();
    n_tests++;
    if (hit_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_hit_saturate: got %h want %h", hit_count, 16'hFFFF);
    end
    n_tests++;
    if (miss_count !== 16'd2) begin
      n_fail++;
      $display("FAIL perf_miss_stable: got %0d want %0d", miss_count, 2);
    end
    mem_read = 1'b0; hit = 1'b0;
    next_cycle();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_store();
    test_reset_mid_refill();
`ifdef CACHE_CTRL_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- FSM that sequences the direct-mapped 128-word, 4-word-block cache data/tag array for CPU load/store requests.
- Sits between the CPU memory port and the cache array plus main memory.
- Policy: write-through, no-write-allocate, 4-beat block refill on read miss.
- Drives the array strobes (write_in_cache, read_from_cache, move_to_cache) and stalls the CPU while main memory is busy.

Parameters:
- BLOCK_WORDS, 4, words per cache block = refill beats per miss.
- BEAT_W, 2, width of the beat counter (log2 BLOCK_WORDS).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- mem_read  input  1  CPU load request, held until stall is low.
- mem_write  input  1  CPU store request, held until stall is low.
- hit  input  1  tag-match/valid result from the cache array for the current word address (combinational).
- mem_ready  input  1  main memory: read beat valid, or write accepted, this cycle.
- read_from_cache  output  1  array read enable.
- write_in_cache  output  1  array single-word write strobe (store hit).
- move_to_cache  output  1  array refill strobe; one word per asserted cycle.
- mem_rd_req  output  1  main-memory block read request.
- mem_wr_req  output  1  main-memory word write request.
- refill_beat  output  BEAT_W  index of the word being fetched; main-memory address low bits.
- stall  output  1  CPU hold.

Behaviour:
- Reset:
  - state=IDLE, beat counter=0.
  - All outputs 0, driven from rst directly in the same cycle.
  - Reset mid-refill or mid-write abandons the transaction; no further strobes.
- States: IDLE, REFILL, WRITE_MEM, WRITE_DONE. Outputs decode from state plus inputs, Mealy style.
- IDLE:
  - No request: all outputs 0; stay in IDLE.
  - mem_read & hit: read_from_cache=1, stall=0 in the same cycle (zero-wait hit); stay in IDLE.
  - mem_read & !hit: stall=1, mem_rd_req=1; next state REFILL; beat counter=0.
  - mem_write (any hit): stall=1; write_in_cache=1 only if hit, for this single cycle; next state WRITE_MEM.
  - mem_read & mem_write together is illegal; it is treated as a write.
- REFILL:
  - stall=1, mem_rd_req=1, refill_beat=beat counter.
  - Each cycle with mem_ready=1: move_to_cache=1 for that cycle and the beat counter increments.
  - mem_ready=0 holds all state; wait is unbounded.
  - On the beat with counter=BLOCK_WORDS-1 and mem_ready=1: counter wraps to 0; next state IDLE.
  - The array tag is valid on the following cycle, so the held read then hits in IDLE: one-cycle read, stall released.
  - Miss penalty = BLOCK_WORDS ready beats + 1 cycle.
- WRITE_MEM:
  - stall=1, mem_wr_req=1.
  - mem_ready=1: next state WRITE_DONE.
- WRITE_DONE:
  - stall=0 for exactly one cycle; requests are ignored; next state IDLE.
  - This prevents re-issuing the held store.
- move_to_cache and write_in_cache are never asserted in the same cycle.
- mem_rd_req and mem_wr_req are never asserted in the same cycle.

Optional Feature:
- CACHE_CTRL_PERF_CNT_EN defined:
  - Adds outputs hit_count[CNT_W-1:0] and miss_count[CNT_W-1:0]. Both reset to 0 and saturate at all-ones.
  - hit_count increments once per IDLE cycle with mem_read & hit.
  - miss_count increments once per IDLE-to-REFILL transition.
- Undefined: neither the ports nor the counter logic exist.

Decomposition:
- Package cache_ctrl_pkg holds:
  - state enum: IDLE=2'd0, REFILL=2'd1, WRITE_MEM=2'd2, WRITE_DONE=2'd3;
  - BLOCK_WORDS and BEAT_W constants.
- Optional sub-module cache_perf_counter: a saturating CNT_W counter, instantiated twice under the macro.
- The FSM itself is not split further.

Test Plan:
- Reset: rst=1 for 2 cycles with mem_read=1 -> all outputs 0, state IDLE; release -> no strobe until a request is presented.
- Read hit: mem_read=1, hit=1 -> same-cycle read_from_cache=1, stall=0; no memory request issued.
- Read miss with gaps: mem_read=1, hit=0; mem_ready pattern 1,0,1,1,0,1 -> move_to_cache on exactly the 4 ready cycles; refill_beat sequence 0,1,2,3; next cycle with hit=1 gives read_from_cache=1, stall=0.
- Store hit then store miss:
  - Hit: write_in_cache=1 for one cycle; mem_wr_req held until mem_ready; then one stall=0 cycle.
  - Miss: write_in_cache stays 0 throughout.
- Reset mid-refill: assert rst after beat 2 -> next cycle IDLE, mem_rd_req=0; a new miss restarts at refill_beat=0.
- With CACHE_CTRL_PERF_CNT_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2; preload hit_count at all-ones -> it stays all-ones.
